// File: rtl/jsq2_pulse_gen.sv
// ---------------------------------------------------------------------------
// jsq2_pulse_gen
//
// Triggered delayed-pulse generator. A single-cycle strobe on en arms an
// internal counter. dout then stays low for DELAY clocks and goes high for
// exactly WIDTH clocks. While a pulse is in flight, further triggers are
// ignored. A trigger that arrives on the clock edge where the run finishes
// is accepted, and it starts the next pulse with identical timing.
//
// Parameters
//   DELAY  clocks dout stays low after the trigger edge (>= 1)
//   WIDTH  clocks dout stays high (>= 1)
//   CNT_W  counter width, 2**CNT_W >= DELAY+WIDTH
//
// Ports
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset
//   en     in   trigger strobe, sampled on rising clk
//   dout   out  delayed pulse, driven directly from a flop
// ---------------------------------------------------------------------------
module jsq2_pulse_gen #(
   parameter int DELAY = 3,
   parameter int WIDTH = 2,
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic dout
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   // Counter value at which dout first goes high, and the last value of a run.
   localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DELAY + WIDTH - 1);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dout_nxt;

   // Next-state / counter logic. In RUN, cnt holds the number of edges seen
   // since the trigger edge. The final edge of a run also samples en, so that
   // back-to-back triggers produce pulses with no lost clock.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (cnt == LAST_CNT) begin
               state_nxt = en ? RUN : IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // dout is decoded from the next state, then registered. This places the
   // high window exactly on edges T+DELAY .. T+DELAY+WIDTH-1. There is no
   // combinational path from en to the output.
   always_comb begin
      dout_nxt = (state_nxt == RUN) && (cnt_nxt >= HIGH_START) && (cnt_nxt <= LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dout  <= dout_nxt;
      end
   end

endmodule

// File: tb/tb_jsq2_pulse_gen.sv
module tb_jsq2_pulse_gen;

   logic clk;
   logic rst_n;
   logic en;
   logic dout;

   int n_checks;
   int n_fail;

   jsq2_pulse_gen #(.DELAY(3), .WIDTH(2), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .dout  (dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic exp);
      n_checks++;
      assert (dout === exp) else begin
         n_fail++;
         $error("FAIL %s: dout=%0b expected %0b", tag, dout, exp);
      end
   endtask

   // Drive en ahead of the next rising edge. Then sample 1 time unit after
   // that edge.
   task automatic cycle(input logic en_val, input logic exp, input string tag);
      en = en_val;
      @(posedge clk);
      #1;
      en = 1'b0;
      check(tag, exp);
   endtask

   // Single trigger followed by the default 3-low / 2-high / back-low shape.
   task automatic pulse(input string tag);
      cycle(1'b1, 1'b0, {tag, "_T"});
      cycle(1'b0, 1'b0, {tag, "_T1"});
      cycle(1'b0, 1'b0, {tag, "_T2"});
      cycle(1'b0, 1'b1, {tag, "_T3"});
      cycle(1'b0, 1'b1, {tag, "_T4"});
      cycle(1'b0, 1'b0, {tag, "_T5"});
   endtask

   logic [15:0] hold_exp;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      #1;
      check("reset_async", 1'b0);

      // Reset held for 10 clocks. en is pulsed during reset and must be ignored.
      for (int i = 0; i < 10; i++) begin
         en = (i == 4 || i == 9);
         @(posedge clk);
         #1;
         check("reset_hold", 1'b0);
      end
      en    = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "post_reset_idle");

      // Single trigger, then the rest of a 10-clock idle window.
      pulse("single");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, "single_idle");

      // Two isolated triggers, 11 clocks apart.
      pulse("iso_a");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, "iso_gap");
      pulse("iso_b");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "iso_tail");

      // en re-asserted at T+2 and T+4 while busy: both are ignored.
      cycle(1'b1, 1'b0, "busy_T");
      cycle(1'b0, 1'b0, "busy_T1");
      cycle(1'b1, 1'b0, "busy_T2_en");
      cycle(1'b0, 1'b1, "busy_T3");
      cycle(1'b1, 1'b1, "busy_T4_en");
      cycle(1'b0, 1'b0, "busy_T5");
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "busy_no_restart");

      // en on the edge where the run ends: accepted as a back-to-back trigger.
      cycle(1'b1, 1'b0, "b2b_T");
      cycle(1'b0, 1'b0, "b2b_T1");
      cycle(1'b0, 1'b0, "b2b_T2");
      cycle(1'b0, 1'b1, "b2b_T3");
      cycle(1'b0, 1'b1, "b2b_T4");
      cycle(1'b1, 1'b0, "b2b_T5_retrig");
      cycle(1'b0, 1'b0, "b2b_U1");
      cycle(1'b0, 1'b0, "b2b_U2");
      cycle(1'b0, 1'b1, "b2b_U3");
      cycle(1'b0, 1'b1, "b2b_U4");
      cycle(1'b0, 1'b0, "b2b_U5");
      cycle(1'b0, 1'b0, "b2b_idle");

      // en held high for 12 clocks. It retriggers every 5 clocks.
      // Expected output after edges T+0 .. T+15, with T+0 in bit 15.
      hold_exp = 16'b0001100011000110;
      for (int k = 0; k < 16; k++) cycle(k < 12, hold_exp[15-k], "hold_en");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "hold_idle");

      // Reset while dout is high aborts the pulse immediately.
      cycle(1'b1, 1'b0, "abort_T");
      cycle(1'b0, 1'b0, "abort_T1");
      cycle(1'b0, 1'b0, "abort_T2");
      cycle(1'b0, 1'b1, "abort_T3");
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_clear", 1'b0);
      @(posedge clk);
      #1;
      check("abort_hold", 1'b0);
      @(posedge clk);
      #1;
      check("abort_hold", 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "abort_no_resume");

      // After release, a trigger behaves as a fresh one.
      pulse("fresh");
      cycle(1'b0, 1'b0, "fresh_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
